// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss controller: stalls the pipeline, writes back a dirty victim as beats,
// then reads the missing block as beats and writes it into the dcache in one strobe.
module dcache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_mem_access,
  input  logic                   i_dcache_hit,
  input  logic                   i_dcache_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0] i_victim_block,
  output logic                   o_stall,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_req_valid,
  input  logic                   i_req_ready,
  output logic                   o_req_we,
  output logic [ADDR_WIDTH-1:0]  o_req_addr,
  output logic                   o_wvalid,
  input  logic                   i_wready,
  output logic [DATA_WIDTH-1:0]  o_wdata,
  input  logic                   i_rvalid,
  input  logic [DATA_WIDTH-1:0]  i_rdata
);

  localparam int unsigned Beats = BLOCK_WIDTH / DATA_WIDTH;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned Offs  = $clog2(BLOCK_WIDTH / 8);

  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWbReq  = 3'd1;
  localparam logic [2:0] StWbData = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;
  localparam logic [2:0] StFill   = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  miss_addr_q, miss_addr_d;
  logic [ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;
  logic [BLOCK_WIDTH-1:0] victim_q, victim_d;
  logic [BLOCK_WIDTH-1:0] buf_q, buf_d;

  logic        miss;
  int unsigned beat_lsb;

  // Block offset bits are dropped when forming block-aligned addresses.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[Offs-1:0], i_addr_wb[Offs-1:0]};

  assign miss     = i_mem_access & ~i_dcache_hit;
  assign beat_lsb = 32'(cnt_q) * DATA_WIDTH;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_addr_d = miss_addr_q;
    wb_addr_d   = wb_addr_q;
    victim_d    = victim_q;
    buf_d       = buf_q;
    unique case (state_q)
      StIdle: begin
        if (miss) begin
          miss_addr_d = {i_addr[ADDR_WIDTH-1:Offs], {Offs{1'b0}}};
          if (i_dcache_dirty) begin
            victim_d  = i_victim_block;
            wb_addr_d = {i_addr_wb[ADDR_WIDTH-1:Offs], {Offs{1'b0}}};
            state_d   = StWbReq;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StWbReq: begin
        if (i_req_ready) begin
          cnt_d   = '0;
          state_d = StWbData;
        end
      end
      StWbData: begin
        if (i_wready) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StRdReq;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRdReq: begin
        if (i_req_ready) begin
          cnt_d   = '0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (i_rvalid) begin
          buf_d[beat_lsb +: DATA_WIDTH] = i_rdata;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StFill;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFill: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      victim_q    <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
      wb_addr_q   <= wb_addr_d;
      victim_q    <= victim_d;
      buf_q       <= buf_d;
    end
  end

  // The idle miss term is combinational so the pipeline freezes in the miss cycle itself.
  always_comb begin
    o_stall      = (state_q != StIdle) | miss;
    o_block_we   = (state_q == StFill);
    o_data_block = buf_q;
    o_req_valid  = (state_q == StWbReq) | (state_q == StRdReq);
    o_req_we     = (state_q == StWbReq);
    o_req_addr   = '0;
    if (state_q == StWbReq) begin
      o_req_addr = wb_addr_q;
    end else if (state_q == StRdReq) begin
      o_req_addr = miss_addr_q;
    end
    o_wvalid = (state_q == StWbData);
    o_wdata  = '0;
    if (state_q == StWbData) begin
      o_wdata = victim_q[beat_lsb +: DATA_WIDTH];
    end
  end

endmodule
